// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches one byte per instruction into a holding register for the control unit.
// Optional fetch-wait timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter logic [7:0] RESET_PC       = 8'h00,
  parameter int         TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  input  logic       next,
  input  logic       jump_en,
  input  logic [7:0] jump_addr,
  input  logic       halt,
  output logic [7:0] instruction,
  output logic       inst_valid,
  output logic [7:0] pc,
  output logic       halted,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t     state, state_d;
  logic [7:0] pc_d, instruction_d, mem_addr_d;
  logic       inst_valid_d, mem_req_d, halted_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt, cnt_d;
  logic          fault_d;
`endif

  always_comb begin
    state_d       = state;
    pc_d          = pc;
    instruction_d = instruction;
    mem_addr_d    = mem_addr;
    inst_valid_d  = inst_valid;
    mem_req_d     = mem_req;
    halted_d      = halted;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt;
    fault_d = fault;
`endif
    case (state)
      IDLE: begin
        state_d    = FETCH;
        mem_req_d  = 1'b1;
        mem_addr_d = pc;
`ifdef FETCH_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      FETCH: begin
        // Control inputs are deliberately not looked at here: the fetch must finish.
        if (mem_req && mem_ack) begin
          instruction_d = mem_rdata;
          pc_d          = pc + 8'd1;
          inst_valid_d  = 1'b1;
          mem_req_d     = 1'b0;
          state_d       = HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          fault_d   = 1'b1;
          halted_d  = 1'b1;
          mem_req_d = 1'b0;
          state_d   = HALT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
`endif
      end
      HOLD: begin
        if (halt) begin
          inst_valid_d = 1'b0;
          halted_d     = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = HALT;
        end else if (jump_en || next) begin
          // Jump wins over next; both start a fresh fetch from the new pc.
          pc_d         = jump_en ? jump_addr : pc;
          mem_addr_d   = jump_en ? jump_addr : pc;
          mem_req_d    = 1'b1;
          inst_valid_d = 1'b0;
          state_d      = FETCH;
`ifdef FETCH_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      HALT: begin
        mem_req_d    = 1'b0;
        inst_valid_d = 1'b0;
        halted_d     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= 8'h00;
      inst_valid  <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= 8'h00;
      halted      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt         <= '0;
      fault       <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      instruction <= instruction_d;
      inst_valid  <= inst_valid_d;
      mem_req     <= mem_req_d;
      mem_addr    <= mem_addr_d;
      halted      <= halted_d;
`ifdef FETCH_TIMEOUT_EN
      cnt         <= cnt_d;
      fault       <= fault_d;
`endif
    end
  end

`ifndef FETCH_TIMEOUT_EN
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random fetch/advance traffic against a transaction-level model.
module tb_fetch_unit;
  logic       clk = 1'b0;
  logic       reset, mem_req, mem_ack, next, jump_en, halt;
  logic       inst_valid, halted, fault;
  logic [7:0] mem_addr, mem_rdata, jump_addr, instruction, pc;
  logic [7:0] mem [256];
  logic [7:0] junk;
  logic [7:0] exp_addr;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  // Memory answers only when acking; otherwise the data bus carries noise.
  assign mem_rdata = mem_ack ? mem[mem_addr] : junk;

  fetch_unit #(.RESET_PC(8'h00), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .next(next), .jump_en(jump_en),
    .jump_addr(jump_addr), .halt(halt), .instruction(instruction),
    .inst_valid(inst_valid), .pc(pc), .halted(halted), .fault(fault)
  );

  task automatic step();
    junk = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_ctl();
    next = 1'b0; jump_en = 1'b0; halt = 1'b0; jump_addr = 8'h00;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5;
    clear_ctl();
    mem_ack = 1'b0;
    junk = 8'h00;

    // Reset state
    reset = 1'b1;
    step(); step();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_instr", instruction, 8'h00);
    check("rst_valid", inst_valid, 0);
    check("rst_pc", pc, 8'h00);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);

    // Immediate ack: first fetch of 0xA5
    reset = 1'b0; mem_ack = 1'b1;
    step();
    check("f0_req", mem_req, 1);
    check("f0_addr", mem_addr, 8'h00);
    check("f0_valid", inst_valid, 0);
    step();
    check("f0_instr", instruction, 8'hA5);
    check("f0_valid1", inst_valid, 1);
    check("f0_pc", pc, 8'h01);
    check("f0_req0", mem_req, 0);
    mem_ack = 1'b0;
    step();
    check("hold_instr", instruction, 8'hA5);
    check("hold_valid", inst_valid, 1);

    // Jump beats next
    next = 1'b1; jump_en = 1'b1; jump_addr = 8'h40;
    step(); clear_ctl();
    check("jmp_addr", mem_addr, 8'h40);
    check("jmp_req", mem_req, 1);
    check("jmp_valid0", inst_valid, 0);
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0;
    check("jmp_instr", instruction, mem[8'h40]);
    check("jmp_pc", pc, 8'h41);

    // Halt beats jump and next; HALT is sticky
    halt = 1'b1; jump_en = 1'b1; next = 1'b1; jump_addr = 8'h10;
    step(); clear_ctl();
    check("halt_halted", halted, 1);
    check("halt_req", mem_req, 0);
    check("halt_valid", inst_valid, 0);
    next = 1'b1; jump_en = 1'b1; jump_addr = 8'h22;
    step(); step(); step(); clear_ctl();
    check("halt_req_stay", mem_req, 0);
    check("halt_pc_frozen", pc, 8'h41);
    check("halt_still", halted, 1);

    // pc wrap from 0xFF
    reset = 1'b1; step(); reset = 1'b0; mem_ack = 1'b1;
    step(); step();
    jump_en = 1'b1; jump_addr = 8'hFE;
    step(); clear_ctl();
    check("wrap_jaddr", mem_addr, 8'hFE);
    step();
    check("wrap_pc_ff", pc, 8'hFF);
    mem_ack = 1'b0; next = 1'b1;
    step(); clear_ctl();
    check("wrap_addr_ff", mem_addr, 8'hFF);
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0;
    check("wrap_pc_00", pc, 8'h00);
    check("wrap_instr", instruction, mem[8'hFF]);

    // Delayed ack with jump pulse during the wait
    next = 1'b1;
    step(); clear_ctl();
    step();
    jump_en = 1'b1; jump_addr = 8'h77;
    step(); clear_ctl();
    step();
    check("wait_addr", mem_addr, 8'h00);
    check("wait_req", mem_req, 1);
    check("wait_pc", pc, 8'h00);
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0;
    check("wait_instr", instruction, mem[8'h00]);
    check("wait_pc1", pc, 8'h01);

    // Reset wins over a coincident ack mid-fetch
    next = 1'b1;
    step(); clear_ctl();
    reset = 1'b1; mem_ack = 1'b1;
    step();
    reset = 1'b0; mem_ack = 1'b0;
    check("rstf_instr", instruction, 8'h00);
    check("rstf_valid", inst_valid, 0);
    check("rstf_pc", pc, 8'h00);
    check("rstf_req", mem_req, 0);

    // No ack at all
    step();
`ifdef FETCH_TIMEOUT_EN
    repeat (14) step();
    check("to_req_pre", mem_req, 1);
    check("to_fault_pre", fault, 0);
    step();
    check("to_fault", fault, 1);
    check("to_halted", halted, 1);
    check("to_req", mem_req, 0);
`else
    repeat (20) step();
    check("nto_req", mem_req, 1);
    check("nto_fault", fault, 0);
    check("nto_halted", halted, 0);
`endif

    // Random traffic against a fetch-sequence model
    reset = 1'b1; step(); reset = 1'b0;
    exp_addr = 8'h00;
    for (int t = 0; t < 80; t++) begin
      int k;
      int lat;
      int r;
      k = 0;
      while (!mem_req && k < 4) begin step(); k++; end
      check("rnd_req", mem_req, 1);
      check("rnd_addr", mem_addr, exp_addr);
      lat = $urandom_range(0, 3);
      for (int c = 0; c < lat; c++) begin
        next = 1'($urandom); jump_en = 1'($urandom); halt = 1'($urandom);
        jump_addr = 8'($urandom);
        step();
        check("rnd_wait_addr", mem_addr, exp_addr);
        check("rnd_wait_valid", inst_valid, 0);
      end
      clear_ctl();
      mem_ack = 1'b1;
      step(); mem_ack = 1'b0;
      check("rnd_instr", instruction, mem[exp_addr]);
      check("rnd_valid", inst_valid, 1);
      check("rnd_pc", pc, exp_addr + 8'd1);
      repeat ($urandom_range(0, 2)) step();
      check("rnd_hold", inst_valid, 1);
      r = $urandom_range(0, 15);
      if (r == 0) begin
        halt = 1'b1; next = 1'($urandom); jump_en = 1'($urandom);
        step(); clear_ctl();
        check("rnd_halted", halted, 1);
        check("rnd_halt_req", mem_req, 0);
        reset = 1'b1; step(); reset = 1'b0;
        exp_addr = 8'h00;
      end else if (r < 7) begin
        jump_en = 1'b1; next = 1'($urandom); jump_addr = 8'($urandom);
        exp_addr = jump_addr;
        step(); clear_ctl();
      end else begin
        next = 1'b1;
        exp_addr = exp_addr + 8'd1;
        step(); clear_ctl();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 15: fetch-wait limit; used only when FETCH_TIMEOUT_EN is defined.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_req  output  1  instruction-memory read request.
REQ-006 mem_addr  output  8  read address; equals pc while mem_req=1.
REQ-007 mem_rdata  input  8  read data; valid when mem_ack=1.
REQ-008 mem_ack  input  1  read complete; sampled only while mem_req=1.
REQ-009 next  input  1  control unit done with current instruction; advance sequentially.
REQ-010 jump_en  input  1  load jump_addr into PC and fetch from it.
REQ-011 jump_addr  input  8  jump target.
REQ-012 halt  input  1  control unit entered halt state.
REQ-013 instruction  output  8  registered instruction; feeds control unit instruction input.
REQ-014 inst_valid  output  1  instruction holds a fetched, unconsumed instruction.
REQ-015 pc  output  8  address of the next fetch.
REQ-016 halted  output  1  unit is in HALT.
REQ-017 fault  output  1  fetch timed out (FETCH_TIMEOUT_EN only).

Function
REQ-018 FSM states SHALL be IDLE, FETCH, HOLD, HALT; all outputs registered.
REQ-019 IDLE: one cycle after reset deasserts -> FETCH unconditionally.
REQ-020 FETCH: mem_req=1, mem_addr=pc held stable until mem_ack sampled high; ack in the first FETCH cycle SHALL be accepted.
REQ-021 On ack in FETCH: instruction<=mem_rdata, pc<=pc+1 mod 256 (8'hFF wraps to 8'h00), inst_valid<=1, mem_req<=0, -> HOLD; minimum latency FETCH entry to inst_valid=1 is 1 cycle.
REQ-022 HOLD: instruction and inst_valid=1 stable until an advance event.
REQ-023 HOLD priority, highest first: halt -> HALT; jump_en -> pc<=jump_addr, FETCH; next -> FETCH.
REQ-024 Leaving HOLD by any event: inst_valid<=0 in the same clock edge.
REQ-025 next, jump_en, halt SHALL be ignored in IDLE, FETCH, HALT; an in-flight fetch always completes.
REQ-026 HALT: mem_req=0, inst_valid=0, halted=1, pc frozen; exit only by reset.
REQ-027 mem_rdata SHALL be ignored when mem_ack=0 or mem_req=0.

Reset
REQ-028 reset=1 at a clock edge: state<=IDLE, pc<=RESET_PC, instruction<=8'h00, inst_valid<=0, mem_req<=0, mem_addr<=8'h00, halted<=0, fault<=0, timeout counter<=0.
REQ-029 Reset SHALL take priority over every other input in any state, including mid-fetch; a mem_ack coincident with reset SHALL be discarded.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN defined: counter increments each FETCH cycle without ack, clears on FETCH entry; if it reaches TIMEOUT_CYCLES without ack, fault<=1, mem_req<=0, -> HALT (halted=1); fault cleared only by reset.
REQ-031 FETCH_TIMEOUT_EN undefined: no counter, fault tied 0, FETCH waits indefinitely for mem_ack.

Verification
REQ-032 Reset, mem_ack same cycle as every req, rdata=8'hA5 at addr 0 -> instruction=8'hA5, inst_valid=1, pc=8'h01 one cycle after FETCH entry.
REQ-033 In HOLD at pc=8'hFF, next=1 -> fetch from 8'hFF, then pc=8'h00 after ack.
REQ-034 In HOLD, next=1, jump_en=1, jump_addr=8'h40 same cycle -> mem_addr=8'h40 next fetch, pc=8'h41 after ack; with halt=1 also asserted -> HALT, halted=1, mem_req stays 0.
REQ-035 mem_ack delayed 3 cycles, jump_en pulsed during wait -> mem_addr unchanged, jump ignored, instruction from original address.
REQ-036 Reset asserted during FETCH with mem_ack=1 -> instruction=8'h00, inst_valid=0, pc=RESET_PC next cycle.
REQ-037 FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=15, mem_ack held 0 -> fault=1, halted=1, mem_req=0 after 15 FETCH cycles; undefined -> mem_req stays 1, fault=0.
